// File: rtl/battle_pkg.sv
// Shared types and constants for the battleship board controller.
package battle_pkg;

   // Board life cycle: no ships, ships placed and shootable, all ships sunk.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      OVER  = 2'd2
   } state_e;

   // Operating modes selected by the front-end switches.
   localparam logic [1:0] MODE_IDLE   = 2'b00;
   localparam logic [1:0] MODE_PLACE  = 2'b01;
   localparam logic [1:0] MODE_ATTACK = 2'b10;
   localparam logic [1:0] MODE_REVEAL = 2'b11;

   // Outcome of one attack request.
   typedef enum logic [1:0] {
      RES_HIT,
      RES_MISS,
      RES_REPEAT,
      RES_INVALID
   } res_e;

   // Status LED colour {r,g} for a result: green hit, red miss, both otherwise.
   function automatic logic [1:0] rgb_of(res_e code);
      case (code)
         RES_HIT:  return 2'b01;
         RES_MISS: return 2'b10;
         default:  return 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/battle_scan_driver.sv
// Column-scanned LED matrix driver: a prescaler steps a column index, and the
// registered one-hot column select and row data are updated together so the
// pins always show a consistent column.
module battle_scan_driver
   import battle_pkg::*;
#(
   parameter int ROWS     = 7,
   parameter int COLS     = 5,
   parameter int SCAN_DIV = 1024
) (
   input  logic                 clk,
   input  logic                 clr,
   input  logic [ROWS*COLS-1:0] disp,
   output logic [COLS-1:0]      m_col,
   output logic [ROWS-1:0]      m_line
);

   localparam int PW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CIW = $clog2(COLS);

   logic [PW-1:0]   presc_q, presc_d;
   logic [CIW-1:0]  col_q, col_d;
   logic [COLS-1:0] m_col_q, m_col_d;
   logic [ROWS-1:0] m_line_q, m_line_d;
   logic            presc_wrap;

   // Next prescaler/column values and the column image that goes with them.
   // NOTE: every signal driven here gets a value on every path first, otherwise
   // synthesis infers a latch to hold the old value.
   always_comb begin
      presc_wrap = (presc_q == PW'(SCAN_DIV - 1));
      presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
      col_d      = col_q;
      if (presc_wrap) begin
         col_d = (col_q == CIW'(COLS - 1)) ? '0 : col_q + 1'b1;
      end
      m_col_d  = COLS'(1) << col_d;
      m_line_d = '0;
      for (int r = 0; r < ROWS; r++) begin
         m_line_d[r] = disp[r*COLS + int'(col_d)];
      end
   end

   // Scan registers; column select and row data change on the same edge.
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         presc_q  <= '0;
         col_q    <= '0;
         m_col_q  <= COLS'(1);
         m_line_q <= '0;
      end else begin
         presc_q  <= presc_d;
         col_q    <= col_d;
         m_col_q  <= m_col_d;
         m_line_q <= m_line_d;
      end
   end

   assign m_col  = m_col_q;
   assign m_line = m_line_q;

endmodule

// File: rtl/battle_board_ctrl.sv
// Battleship board controller: ship and shot maps, attack resolution with a
// one-cycle result pulse, hit/shot counters, game-over detection, status RGB
// and the scanned LED matrix.
module battle_board_ctrl
   import battle_pkg::*;
#(
   parameter  int ROWS     = 7,
   parameter  int COLS     = 5,
   parameter  int SCAN_DIV = 1024,
   localparam int N        = ROWS * COLS,
   localparam int RW       = $clog2(ROWS),
   localparam int CW       = $clog2(COLS),
   localparam int NW       = $clog2(ROWS * COLS + 1)
) (
   input  logic            clk,
   input  logic            clr,
   input  logic [1:0]      mode,
   input  logic [N-1:0]    place_map,
   input  logic            place_load,
   input  logic [RW-1:0]   at_row,
   input  logic [CW-1:0]   at_col,
   input  logic            at_valid,
   output logic            res_valid,
   output logic            res_hit,
   output logic            res_miss,
   output logic            res_repeat,
   output logic            res_invalid,
   output logic [NW-1:0]   hits_cnt,
   output logic [NW-1:0]   shots_cnt,
   output logic            game_over,
   output logic [COLS-1:0] m_col,
   output logic [ROWS-1:0] m_line,
   output logic            rgb_r,
   output logic            rgb_g
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   logic [N-1:0]  ship_q, ship_d, shot_q, shot_d;
   logic [NW-1:0] total_q, total_d, hits_q, hits_d, shots_q, shots_d;
   state_e        state_q, state_d;
   logic          res_valid_q, res_valid_d;
   res_e          res_code_q, res_code_d;
   logic [1:0]    rgb_q, rgb_d;

   logic          load, attack, in_range;
   logic [IW-1:0] cell_idx;
   logic [N-1:0]  disp;

   // Decode requests. A load takes precedence over a same-cycle attack, and an
   // idle board has nothing to shoot at, so attacks there are dropped silently.
   always_comb begin
      load     = place_load && (mode == MODE_PLACE);
      attack   = at_valid && (mode == MODE_ATTACK) && (state_q != IDLE) && !load;
      in_range = (int'(at_row) < ROWS) && (int'(at_col) < COLS);
      cell_idx = in_range ? IW'(int'(at_row) * COLS + int'(at_col)) : '0;
   end

   // Next-state logic: map load, game-over transition, attack resolution.
   always_comb begin
      ship_d      = ship_q;
      shot_d      = shot_q;
      total_d     = total_q;
      hits_d      = hits_q;
      shots_d     = shots_q;
      state_d     = state_q;
      res_valid_d = 1'b0;
      res_code_d  = res_code_q;
      rgb_d       = rgb_q;

      if (load) begin
         // A new map starts a fresh game, including a dark status LED.
         ship_d  = place_map;
         total_d = NW'($countones(place_map));
         shot_d  = '0;
         hits_d  = '0;
         shots_d = '0;
         rgb_d   = 2'b00;
         state_d = (place_map != '0) ? ARMED : IDLE;
      end else begin
         if (state_q == ARMED && hits_q == total_q) begin
            state_d = OVER;
         end
         if (attack) begin
            res_valid_d = 1'b1;
            if (state_q != ARMED || !in_range) begin
               res_code_d = RES_INVALID;
            end else if (shot_q[cell_idx]) begin
               res_code_d = RES_REPEAT;
            end else begin
               shot_d[cell_idx] = 1'b1;
               shots_d          = shots_q + 1'b1;
               if (ship_q[cell_idx]) begin
                  hits_d     = hits_q + 1'b1;
                  res_code_d = RES_HIT;
               end else begin
                  res_code_d = RES_MISS;
               end
            end
            rgb_d = rgb_of(res_code_d);
         end
      end
   end

   // Board state registers.
   // NOTE: the maps are small flop arrays rather than a RAM, so they take the
   // async reset like every other register.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         ship_q      <= '0;
         shot_q      <= '0;
         total_q     <= '0;
         hits_q      <= '0;
         shots_q     <= '0;
         state_q     <= IDLE;
         res_valid_q <= 1'b0;
         res_code_q  <= RES_HIT;
         rgb_q       <= 2'b00;
      end else begin
         ship_q      <= ship_d;
         shot_q      <= shot_d;
         total_q     <= total_d;
         hits_q      <= hits_d;
         shots_q     <= shots_d;
         state_q     <= state_d;
         res_valid_q <= res_valid_d;
         res_code_q  <= res_code_d;
         rgb_q       <= rgb_d;
      end
   end

   // Matrix content: ships while placing/revealing, shots while attacking, and
   // the sunk cells once the game is over.
   always_comb begin
      case (mode)
         MODE_PLACE, MODE_REVEAL: disp = ship_q;
         MODE_ATTACK:             disp = (state_q == OVER) ? (ship_q & shot_q) : shot_q;
         default:                 disp = '0;
      endcase
   end

   battle_scan_driver #(
      .ROWS     (ROWS),
      .COLS     (COLS),
      .SCAN_DIV (SCAN_DIV)
   ) u_scan (
      .clk    (clk),
      .clr    (clr),
      .disp   (disp),
      .m_col  (m_col),
      .m_line (m_line)
   );

   assign res_valid   = res_valid_q;
   assign res_hit     = res_valid_q && (res_code_q == RES_HIT);
   assign res_miss    = res_valid_q && (res_code_q == RES_MISS);
   assign res_repeat  = res_valid_q && (res_code_q == RES_REPEAT);
   assign res_invalid = res_valid_q && (res_code_q == RES_INVALID);
   assign hits_cnt    = hits_q;
   assign shots_cnt   = shots_q;
   assign game_over   = (state_q == OVER);
   // Game over forces green regardless of the last result.
   assign rgb_r       = game_over ? 1'b0 : rgb_q[1];
   assign rgb_g       = game_over ? 1'b1 : rgb_q[0];

endmodule

// File: tb/tb_battle_board_ctrl.sv
// Bench for battle_board_ctrl: a 7x5 board (SCAN_DIV=4) and an 8x8 board
// (SCAN_DIV=3) run side by side against a behavioural board model.
module tb_battle_board_ctrl;

   localparam int R0 = 7, C0 = 5, S0 = 4;
   localparam int R1 = 8, C1 = 8, S1 = 3;

   logic clk = 1'b0;
   logic clr = 1'b0;
   always #5 clk = ~clk;

   // Stimulus, one slot per board.
   logic [1:0]  mode_v [2];
   logic [63:0] map_v  [2];
   logic        load_v [2];
   logic        atv_v  [2];
   logic [2:0]  row_v  [2];
   logic [2:0]  colv_v [2];

   logic rv_a, hit_a, miss_a, rep_a, inv_a, go_a, r_a, g_a;
   logic [5:0] hits_a, shots_a;
   logic [4:0] mcol_a;
   logic [6:0] mline_a;
   logic rv_b, hit_b, miss_b, rep_b, inv_b, go_b, r_b, g_b;
   logic [6:0] hits_b, shots_b;
   logic [7:0] mcol_b;
   logic [7:0] mline_b;

   battle_board_ctrl #(.ROWS(R0), .COLS(C0), .SCAN_DIV(S0)) dut_a (
      .clk(clk), .clr(clr), .mode(mode_v[0]), .place_map(map_v[0][34:0]),
      .place_load(load_v[0]), .at_row(row_v[0]), .at_col(colv_v[0]), .at_valid(atv_v[0]),
      .res_valid(rv_a), .res_hit(hit_a), .res_miss(miss_a), .res_repeat(rep_a),
      .res_invalid(inv_a), .hits_cnt(hits_a), .shots_cnt(shots_a), .game_over(go_a),
      .m_col(mcol_a), .m_line(mline_a), .rgb_r(r_a), .rgb_g(g_a));

   battle_board_ctrl #(.ROWS(R1), .COLS(C1), .SCAN_DIV(S1)) dut_b (
      .clk(clk), .clr(clr), .mode(mode_v[1]), .place_map(map_v[1]),
      .place_load(load_v[1]), .at_row(row_v[1]), .at_col(colv_v[1]), .at_valid(atv_v[1]),
      .res_valid(rv_b), .res_hit(hit_b), .res_miss(miss_b), .res_repeat(rep_b),
      .res_invalid(inv_b), .hits_cnt(hits_b), .shots_cnt(shots_b), .game_over(go_b),
      .m_col(mcol_b), .m_line(mline_b), .rgb_r(r_b), .rgb_g(g_b));

   // Observed outputs in a common shape: flags = {valid,hit,miss,repeat,invalid,over,r,g}.
   logic [7:0]  a_flags [2];
   logic [7:0]  a_hits  [2];
   logic [7:0]  a_shots [2];
   logic [63:0] a_mcol  [2];
   logic [63:0] a_mline [2];
   assign a_flags[0] = {rv_a, hit_a, miss_a, rep_a, inv_a, go_a, r_a, g_a};
   assign a_flags[1] = {rv_b, hit_b, miss_b, rep_b, inv_b, go_b, r_b, g_b};
   assign a_hits[0]  = {2'b00, hits_a};
   assign a_hits[1]  = {1'b0, hits_b};
   assign a_shots[0] = {2'b00, shots_a};
   assign a_shots[1] = {1'b0, shots_b};
   assign a_mcol[0]  = {59'd0, mcol_a};
   assign a_mcol[1]  = {56'd0, mcol_b};
   assign a_mline[0] = {57'd0, mline_a};
   assign a_mline[1] = {56'd0, mline_b};

   // Behavioural model. State: 0 idle, 1 armed, 2 over. Code: 0 hit, 1 miss, 2 repeat, 3 invalid.
   logic [63:0] m_ship [2], m_shot [2], m_mcol [2], m_mline [2];
   int          m_total [2], m_hits [2], m_shots [2], m_st [2], m_code [2], m_n [2];
   logic        m_rv [2];
   logic [1:0]  m_rgb [2];

   // Ship cells of the last generated map, used to aim some random shots.
   int cr [2][3];
   int cc [2][3];
   int nc [2];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int rows_of(input int k); return (k == 0) ? R0 : R1; endfunction
   function automatic int cols_of(input int k); return (k == 0) ? C0 : C1; endfunction
   function automatic int div_of(input int k);  return (k == 0) ? S0 : S1; endfunction

   task automatic model_reset(input int k);
      m_ship[k]  = '0;  m_shot[k]  = '0;
      m_total[k] = 0;   m_hits[k]  = 0;  m_shots[k] = 0;
      m_st[k]    = 0;   m_code[k]  = 0;  m_rv[k]    = 1'b0;
      m_rgb[k]   = 2'b00;
      m_n[k]     = 0;
      m_mcol[k]  = 64'd1;
      m_mline[k] = '0;
   endtask

   // One rising edge of board k, from the inputs presented before the edge.
   task automatic model_edge(input int k);
      int R, C, SD, col, idx, st_old;
      logic [63:0] disp, mask;
      R  = rows_of(k);
      C  = cols_of(k);
      SD = div_of(k);
      case (mode_v[k])
         2'b01, 2'b11: disp = m_ship[k];
         2'b10:        disp = (m_st[k] == 2) ? (m_ship[k] & m_shot[k]) : m_shot[k];
         default:      disp = '0;
      endcase
      m_n[k]     = m_n[k] + 1;
      col        = (m_n[k] / SD) % C;
      m_mcol[k]  = 64'd1 << col;
      m_mline[k] = '0;
      for (int r = 0; r < R; r++) m_mline[k][r] = disp[r*C + col];
      m_rv[k] = 1'b0;
      if (load_v[k] && mode_v[k] == 2'b01) begin
         mask       = (R * C == 64) ? '1 : ((64'd1 << (R * C)) - 64'd1);
         m_ship[k]  = map_v[k] & mask;
         m_total[k] = $countones(m_ship[k]);
         m_shot[k]  = '0;
         m_hits[k]  = 0;
         m_shots[k] = 0;
         m_rgb[k]   = 2'b00;
         m_st[k]    = (m_total[k] > 0) ? 1 : 0;
      end else begin
         st_old = m_st[k];
         if (st_old == 1 && m_hits[k] == m_total[k]) m_st[k] = 2;
         if (atv_v[k] && mode_v[k] == 2'b10 && st_old != 0) begin
            m_rv[k] = 1'b1;
            if (st_old != 1 || int'(row_v[k]) >= R || int'(colv_v[k]) >= C) begin
               m_code[k] = 3;
            end else begin
               idx = int'(row_v[k]) * C + int'(colv_v[k]);
               if (m_shot[k][idx]) begin
                  m_code[k] = 2;
               end else begin
                  m_shot[k][idx] = 1'b1;
                  m_shots[k]     = m_shots[k] + 1;
                  if (m_ship[k][idx]) begin
                     m_hits[k] = m_hits[k] + 1;
                     m_code[k] = 0;
                  end else begin
                     m_code[k] = 1;
                  end
               end
            end
            m_rgb[k] = (m_code[k] == 0) ? 2'b01 : (m_code[k] == 1) ? 2'b10 : 2'b11;
         end
      end
   endtask

   task automatic compare_inst(input int k);
      logic [7:0] ef;
      logic       go;
      logic [1:0] rgb;
      go  = (m_st[k] == 2);
      rgb = go ? 2'b01 : m_rgb[k];
      ef  = {m_rv[k], m_rv[k] && m_code[k] == 0, m_rv[k] && m_code[k] == 1,
             m_rv[k] && m_code[k] == 2, m_rv[k] && m_code[k] == 3, go, rgb};
      check($sformatf("flags_b%0d", k), a_flags[k], ef);
      check($sformatf("hits_b%0d", k),  a_hits[k],  m_hits[k]);
      check($sformatf("shots_b%0d", k), a_shots[k], m_shots[k]);
      check($sformatf("mcol_b%0d", k),  a_mcol[k],  m_mcol[k]);
      check($sformatf("mline_b%0d", k), a_mline[k], m_mline[k]);
   endtask

   // One clock: model follows the edge, outputs checked on the falling edge,
   // then single-cycle pulses are withdrawn.
   task automatic step();
      @(posedge clk);
      if (clr) begin
         model_edge(0);
         model_edge(1);
      end
      @(negedge clk);
      compare_inst(0);
      compare_inst(1);
      for (int k = 0; k < 2; k++) begin
         load_v[k] = 1'b0;
         atv_v[k]  = 1'b0;
      end
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
   task automatic do_reset();
      #2;
      clr = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      compare_inst(0);
      compare_inst(1);
      for (int k = 0; k < 2; k++) begin
         load_v[k] = 1'b0;
         atv_v[k]  = 1'b0;
      end
      @(negedge clk);
      clr = 1'b1;
   endtask

   task automatic load_map(input int k, input logic [63:0] map);
      mode_v[k] = 2'b01;
      map_v[k]  = map;
      load_v[k] = 1'b1;
      step();
   endtask

   task automatic attack(input int k, input int r, input int c);
      mode_v[k] = 2'b10;
      row_v[k]  = 3'(r);
      colv_v[k] = 3'(c);
      atv_v[k]  = 1'b1;
      step();
   endtask

   task automatic gen_map(input int k);
      int R, C;
      R = rows_of(k);
      C = cols_of(k);
      map_v[k] = '0;
      nc[k]    = $urandom_range(0, 3);
      for (int i = 0; i < nc[k]; i++) begin
         cr[k][i] = $urandom_range(0, R - 1);
         cc[k][i] = $urandom_range(0, C - 1);
         map_v[k][cr[k][i]*C + cc[k][i]] = 1'b1;
      end
   endtask

   task automatic rand_inputs(input int k);
      int p, q, j;
      p = $urandom_range(0, 99);
      load_v[k] = 1'b0;
      atv_v[k]  = 1'b0;
      if (p < 5) begin
         mode_v[k] = 2'b01;
         gen_map(k);
         load_v[k] = 1'b1;
         atv_v[k]  = 1'($urandom_range(0, 1));
      end else if (p < 10) begin
         mode_v[k] = 2'($urandom_range(0, 3));
         atv_v[k]  = 1'($urandom_range(0, 1));
         row_v[k]  = 3'($urandom_range(0, 7));
         colv_v[k] = 3'($urandom_range(0, 7));
      end else if (p < 20) begin
         mode_v[k] = 2'b11;
      end else begin
         mode_v[k] = 2'b10;
         atv_v[k]  = 1'($urandom_range(0, 1));
         q = $urandom_range(0, 9);
         if (q < 3 && nc[k] > 0) begin
            j = $urandom_range(0, nc[k] - 1);
            row_v[k]  = 3'(cr[k][j]);
            colv_v[k] = 3'(cc[k][j]);
         end else if (q < 9) begin
            row_v[k]  = 3'($urandom_range(0, rows_of(k) - 1));
            colv_v[k] = 3'($urandom_range(0, cols_of(k) - 1));
         end else begin
            row_v[k]  = 3'($urandom_range(0, 7));
            colv_v[k] = 3'($urandom_range(0, 7));
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         mode_v[k] = 2'b00; map_v[k] = '0; load_v[k] = 1'b0;
         atv_v[k]  = 1'b0;  row_v[k] = '0; colv_v[k] = '0;
         nc[k]     = 0;
         model_reset(k);
      end

      // Reset state.
      #12;
      compare_inst(0);
      compare_inst(1);
      check("rst_mcol", a_mcol[0], 64'h1);
      check("rst_flags", a_flags[0], 64'h00);
      @(negedge clk);
      clr = 1'b1;

      // Empty map keeps the board idle; attacks there produce nothing.
      load_map(0, 64'h0);
      attack(0, 0, 0);
      check("t1_no_res", a_flags[0], 64'h00);

      // Ships at (0,0) and (6,4).
      load_map(0, 64'h4_0000_0001);
      attack(0, 0, 0);
      check("t2_hit_flags", a_flags[0], 64'hC1);
      check("t2_hits", a_hits[0], 64'd1);
      check("t2_shots", a_shots[0], 64'd1);
      attack(0, 3, 2);
      check("t2_miss_flags", a_flags[0], 64'hA2);
      check("t2_shots2", a_shots[0], 64'd2);

      // Repeat and out-of-range shots.
      attack(0, 0, 0);
      check("t3_repeat_flags", a_flags[0], 64'h93);
      check("t3_hits", a_hits[0], 64'd1);
      check("t3_shots", a_shots[0], 64'd2);
      attack(0, 7, 0);
      check("t3_inv_row", a_flags[0], 64'h8B);
      attack(0, 0, 5);
      check("t3_inv_col", a_flags[0], 64'h8B);

      // Winning hit, game over one edge later, then reload.
      attack(0, 6, 4);
      check("t4_win_flags", a_flags[0], 64'hC1);
      check("t4_hits", a_hits[0], 64'd2);
      step();
      check("t4_over_flags", a_flags[0], 64'h05);
      attack(0, 1, 1);
      check("t4_inv_over", a_flags[0], 64'h8D);
      load_map(0, 64'h4_0000_0001);
      check("t4_reload_flags", a_flags[0], 64'h00);
      check("t4_reload_hits", a_hits[0], 64'd0);
      check("t4_reload_shots", a_shots[0], 64'd0);
      attack(0, 0, 0);
      check("t4_rearmed_hit", a_flags[0], 64'hC1);

      // Load and attack together: load wins, no result.
      mode_v[0] = 2'b01;
      map_v[0]  = 64'h20;
      load_v[0] = 1'b1;
      atv_v[0]  = 1'b1;
      row_v[0]  = 3'd1;
      colv_v[0] = 3'd0;
      step();
      check("t5_no_res", a_flags[0][7], 64'd0);
      check("t5_hits_cleared", a_hits[0], 64'd0);
      attack(0, 1, 0);
      check("t5_hit", a_flags[0], 64'hC1);
      step();
      attack(0, 2, 2);
      check("t5_inv_over", a_flags[0], 64'h8D);
      do_reset();
      check("t5_rst_flags", a_flags[0], 64'h00);
      check("t5_rst_hits", a_hits[0], 64'd0);

      // Scan timing: column steps every SCAN_DIV clocks and wraps.
      do_reset();
      load_map(0, (64'd1 << 11) | (64'd1 << 31));
      mode_v[0] = 2'b11;
      mode_v[1] = 2'b11;
      repeat (3) step();
      check("t6_col1", a_mcol[0], 64'h2);
      check("t6_line1", a_mline[0], 64'h44);
      check("t6b_col1", a_mcol[1], 64'h2);
      repeat (16) step();
      check("t6_wrap", a_mcol[0], 64'h1);
      check("t6b_col6", a_mcol[1], 64'h40);

      // Randomised play on both boards.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         rand_inputs(0);
         rand_inputs(1);
         if ($urandom_range(0, 599) == 0) do_reset();
         else step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
